// File: rtl/sec32_encoder_if.sv
// Stream bundle for the SEC32 encoder: data in on the
// in_* handshake, codeword out on the out_* handshake.
// slave = encoder side, master = source/sink side.
interface sec32_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_check;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_check
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_check
  );
endinterface

// File: rtl/sec32_encoder.sv
// SEC32 encoder: 32-bit data word -> 8 check bits, two-stage
// valid/ready pipeline with a handshake counter.
// Stage 1 holds the word plus nibble parities P and column
// parities Q; stage 2 holds the finished codeword.
// Optional macro SEC_ERR_INJECT_EN adds a one-shot bit-flip
// injector on the word entering stage 2 (bits 0-31 data,
// 32-39 check, 40-63 consume the arm without flipping).
module sec32_encoder #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  sec32_encoder_if.slave     bus,
  output logic [COUNT_W-1:0] word_count
`ifdef SEC_ERR_INJECT_EN
  ,
  input  logic               inj_arm,
  input  logic [5:0]         inj_bit,
  output logic               inj_done
`endif
);

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  p;
    logic [7:0]  q;
  } s1_t;

  logic [2:1]  vld_pipe;
  s1_t         s1_q;
  logic [7:0]  p_nxt, q_nxt;
  logic [7:0]  chk;
  logic [39:0] flip;
  logic        adv1, adv2, acc, ld2, hs;

  // nibble parities P(j) and column parities Q(k)
  for (genvar j = 0; j < 8; j++) begin : g_p
    assign p_nxt[j] = ^bus.in_data[4*j +: 4];
  end
  for (genvar k = 0; k < 4; k++) begin : g_q
    assign q_nxt[k]   = bus.in_data[k]    ^ bus.in_data[k+4]  ^
                        bus.in_data[k+8]  ^ bus.in_data[k+12];
    assign q_nxt[k+4] = bus.in_data[16+k] ^ bus.in_data[20+k] ^
                        bus.in_data[24+k] ^ bus.in_data[28+k];
  end

  // stage 2 moves when empty or drained; stage 1 when empty or stage 2 moves
  assign adv2          = !vld_pipe[2] || bus.out_ready;
  assign adv1          = !vld_pipe[1] || adv2;
  assign bus.in_ready  = !rst && adv1;
  assign acc           = bus.in_valid && bus.in_ready;
  assign ld2           = adv2 && vld_pipe[1];
  assign bus.out_valid = vld_pipe[2];
  assign hs            = vld_pipe[2] && bus.out_ready;

  // valid flags; async reset discards anything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      if (adv1) vld_pipe[1] <= acc;
      if (adv2) vld_pipe[2] <= vld_pipe[1];
    end
  end

  // stage 1 payload capture on input accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      s1_q <= '0;
    else if (acc) s1_q <= '{d: bus.in_data, p: p_nxt, q: q_nxt};
  end

  // check bits from registered parities
  always_comb begin
    chk    = '0;
    chk[0] = s1_q.p[4] ^ s1_q.p[5] ^ s1_q.q[0];
    chk[1] = s1_q.p[6] ^ s1_q.p[7] ^ s1_q.q[1];
    chk[2] = s1_q.p[4] ^ s1_q.p[6] ^ s1_q.q[2];
    chk[3] = s1_q.p[5] ^ s1_q.p[7] ^ s1_q.q[3];
    chk[4] = s1_q.p[0] ^ s1_q.p[1] ^ s1_q.q[4];
    chk[5] = s1_q.p[2] ^ s1_q.p[3] ^ s1_q.q[5];
    chk[6] = s1_q.p[0] ^ s1_q.p[2] ^ s1_q.q[6];
    chk[7] = s1_q.p[1] ^ s1_q.p[3] ^ s1_q.q[7];
  end

`ifdef SEC_ERR_INJECT_EN
  logic       armed, s2_inj, corrupt;
  logic [5:0] bit_q;

  // the word already marked in stage 2 must not re-trigger while armed
  assign corrupt  = armed && !(vld_pipe[2] && s2_inj);
  // shifts of 40 and above fall off the end: arm consumed, nothing flipped
  assign flip     = corrupt ? (40'd1 << bit_q) : '0;
  assign inj_done = hs && s2_inj;

  // arm register: re-arm overwrites the bit, handshake of marked word clears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
      bit_q <= '0;
    end else if (inj_arm) begin
      armed <= 1'b1;
      bit_q <= inj_bit;
    end else if (hs && s2_inj) begin
      armed <= 1'b0;
    end
  end

  // marks which word in stage 2 carries the injected flip
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      s2_inj <= 1'b0;
    else if (ld2) s2_inj <= corrupt;
    else if (hs)  s2_inj <= 1'b0;
  end
`else
  assign flip = '0;
`endif

  // stage 2 codeword; held while out_valid && !out_ready since ld2 is low then
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_data  <= '0;
      bus.out_check <= '0;
    end else if (ld2) begin
      bus.out_data  <= s1_q.d ^ flip[31:0];
      bus.out_check <= chk ^ flip[39:32];
    end
  end

  // output handshake counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     word_count <= '0;
    else if (hs) word_count <= word_count + 1'b1;
  end

endmodule

// File: doc/sec32_encoder.md
SEC32_ENCODER -- requirements
Module: sec32_encoder

Interface
REQ-001 SHALL have parameter COUNT_W, default 16, width of the accepted-word counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  source presents a data word.
REQ-005 SHALL have port in_ready  output  1  encoder accepts in_data this cycle.
REQ-006 SHALL have port in_data  input  32  data word d[31:0].
REQ-007 SHALL have port out_valid  output  1  codeword available.
REQ-008 SHALL have port out_ready  input  1  sink accepts the codeword.
REQ-009 SHALL have port out_data  output  32  data part of the codeword.
REQ-010 SHALL have port out_check  output  8  check bits c[7:0].
REQ-011 SHALL have port word_count  output  COUNT_W  number of output handshakes, modulo 2^COUNT_W.

Function
REQ-012 SHALL define P(j) as the XOR of d[4j..4j+3] for j=0..7.
REQ-013 SHALL define Q(k) as d[k]^d[k+4]^d[k+8]^d[k+12] and Q(k+4) as d[16+k]^d[20+k]^d[24+k]^d[28+k] for k=0..3.
REQ-014 SHALL compute the check bits as follows: c0=P4^P5^Q0, c1=P6^P7^Q1, c2=P4^P6^Q2, c3=P5^P7^Q3, c4=P0^P1^Q4, c5=P2^P3^Q5, c6=P0^P2^Q6, c7=P1^P3^Q7, so that the companion 32-bit SEC checker reports a zero syndrome.
REQ-015 SHALL use a 2-stage pipeline: stage 1 registers d, P(0..7) and Q(0..7); stage 2 registers out_data and out_check.
REQ-016 SHALL define input accept as in_valid&in_ready and output handshake as out_valid&out_ready.
REQ-017 SHALL make the latency from input accept to out_valid exactly 2 cycles when there is no backpressure.
REQ-018 SHALL sustain 1 word per cycle with out_ready held high.
REQ-019 SHALL advance stage 2 when it is empty or out_ready=1, and SHALL advance stage 1 when it is empty or stage 2 advances.
REQ-020 SHALL drive in_ready = stage-1 advance condition, which is combinational from out_ready and the valid flags.
REQ-021 SHALL hold out_data and out_check stable while out_valid=1 and out_ready=0.
REQ-022 SHALL never drop or duplicate a word: with both stages full and out_ready=0, in_ready=0.
REQ-023 SHALL accept a new input and complete an output handshake in the same cycle when the pipeline is full.
REQ-024 SHALL increment word_count on each output handshake and SHALL wrap from 2^COUNT_W-1 to 0.
REQ-025 SHALL ignore in_data when in_valid=0.

Reset
REQ-026 SHALL, while rst=1, force out_valid=0, both valid flags=0, out_data=0, out_check=0, word_count=0 and in_ready=0.
REQ-027 SHALL discard words in flight when rst asserts mid-operation; no partial codeword SHALL be emitted after release.
REQ-028 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL, when macro SEC_ERR_INJECT_EN is defined, add inputs inj_arm (1) and inj_bit (6) and output inj_done (1).
REQ-030 SHALL capture inj_bit and set an armed flag when inj_arm=1 (with SEC_ERR_INJECT_EN); re-arming while armed SHALL overwrite inj_bit.
REQ-031 SHALL, while armed, invert bit inj_bit of {out_check,out_data} on the next word loaded into stage 2 (bits 0-31 are data, 32-39 are check).
REQ-032 SHALL treat inj_bit values 40-63 as no flip while still consuming the arm.
REQ-033 SHALL clear the armed flag and pulse inj_done for 1 cycle on the output handshake of the affected word.
REQ-034 SHALL, when SEC_ERR_INJECT_EN is undefined, have none of these ports and no corruption path.
REQ-035 SHALL reset the armed flag to 0.

Verification
REQ-036 SHALL check encoding: in_data 0x00000000 -> out_check 0x00; 0x00000001 -> 0x51; 0x00010000 -> 0x15; 0xFFFFFFFF -> 0x00; each valid 2 cycles after accept.
REQ-037 SHALL check streaming: 100 random words back-to-back with out_ready=1 -> 1 codeword/cycle, order preserved, checker-model syndrome 0, word_count=100.
REQ-038 SHALL check backpressure: out_ready=0 for 5 cycles with 3 words offered -> in_ready drops after 2 accepts, output held stable, and all 3 words emerge in order after out_ready=1.
REQ-039 SHALL check wrap: COUNT_W=4 with 17 handshakes -> word_count=1.
REQ-040 SHALL check reset mid-stream: rst with both stages full -> out_valid=0 and word_count=0 next cycle; the next accepted word emerges correctly.
REQ-041 SHALL check injection (SEC_ERR_INJECT_EN): inj_bit=35, then word 0x00000001 -> out_check 0x59, inj_done pulses once, and the following word is uncorrupted.
